mig_app_responder: RTL and testbench
====================================

Name: mig_app_responder

Overview:
- Synthesizable responder for the MIG 7-series user (app_*) interface, used in the DDR3 VIP area.
- Stands in for the MIG core so the DDR3 read/write controllers can be simulated and brought up without a DDR3 device.
- Accepts write and read commands, stores write data in on-chip RAM, and returns read data after a fixed latency.
- Provides a calibration-done delay, controllable backpressure and sticky protocol-error flags.

Parameters:
- DATA_W, 128, app data width; one beat = one BL8 burst (4:1 clocking).
- MEM_AW, 10, RAM word-address bits (2^MEM_AW words of DATA_W).
- RD_LAT, 6, cycles from read-command acceptance to app_rd_data_valid (>=2).
- CALIB_CYCLES, 64, cycles after reset before init_calib_complete rises.
- WDF_DEPTH, 4, write-data FIFO depth (power of 2).

Ports:
- ui_clk  in  1  user clock; all logic on its rising edge.
- ui_clk_sync_rst  in  1  reset, synchronous, active-high.
- init_calib_complete  out  1  calibration done.
- app_en  in  1  command valid.
- app_cmd  in  3  0 = write, 1 = read; other codes are illegal.
- app_addr  in  28  byte-beat address; increments by 8 per beat.
- app_rdy  out  1  command ready.
- app_wdf_data  in  DATA_W  write data.
- app_wdf_mask  in  DATA_W/8  byte mask; 1 = byte not written.
- app_wdf_wren  in  1  write data valid.
- app_wdf_end  in  1  last beat of burst; must equal app_wdf_wren.
- app_wdf_rdy  out  1  write-data ready.
- app_rd_data  out  DATA_W  read data.
- app_rd_data_valid  out  1  read data valid, one cycle per beat.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- stall_cmd  in  1  test backpressure: forces app_rdy low.
- stall_wdf  in  1  test backpressure: forces app_wdf_rdy low.
- err_flags  out  3  sticky: [0] illegal cmd, [1] addr[2:0] != 0, [2] wdf_end != wdf_wren.

Behaviour:
- Reset (ui_clk_sync_rst = 1 at an edge) resets all logic; RAM contents are not cleared.
  - Outputs after reset: init_calib_complete = 0, app_rdy = 0, app_wdf_rdy = 0, app_rd_data_valid = 0, app_rd_data_end = 0, app_rd_data = 0, err_flags = 0.
  - FIFO, read pipeline and pending flag are cleared.
  - Reset mid-operation drops in-flight reads (no valid pulse afterwards) and discards buffered write data.
- State machine:
  - CALIB: counter from 0; at count CALIB_CYCLES-1 go to RUN. init_calib_complete is registered, high on the first RUN cycle, i.e. CALIB_CYCLES cycles after reset deasserts.
  - RUN: stays in RUN until reset.
- Handshakes:
  - app_wdf_rdy = RUN && !stall_wdf && FIFO not full.
  - Data beat accepted when app_wdf_wren && app_wdf_rdy.
  - app_rdy = RUN && !stall_cmd && !wr_pend.
  - Command accepted when app_en && app_rdy.
- Write execution:
  - Data source: FIFO head, or a beat accepted in the same cycle when the FIFO is empty (bypass).
  - Write command accepted with data available: RAM is written that cycle (FIFO pops, or the bypass beat is consumed).
  - Write command accepted with no data available: set wr_pend and latch the address. The write executes on the first cycle data becomes available; wr_pend clears the next cycle.
  - Data beats may precede their commands by up to WDF_DEPTH beats.
  - Each byte whose mask bit is 0 is updated; masked bytes keep their old value.
- Read execution:
  - RAM is read at acceptance; result enters an RD_LAT-stage shift pipeline.
  - app_rd_data_valid pulses exactly RD_LAT cycles after acceptance.
  - Back-to-back reads return back-to-back, in command order.
  - No read-data backpressure.
  - Ordering: wr_pend blocks app_rdy, so a read always sees every previously accepted write.
- RAM index = app_addr[MEM_AW+2:3]. Higher bits are ignored, so addresses wrap (no error).
- err_flags:
  - [0] set when an accepted command has app_cmd not in {0,1}; that command is otherwise ignored.
  - [1] set when an accepted command has app_addr[2:0] != 0; the command still executes with bits [2:0] ignored.
  - [2] set on any cycle where app_wdf_end != app_wdf_wren.
  - All bits are sticky until reset.
- Simultaneous data beat accepted and FIFO pop in one cycle: FIFO count is unchanged.
- Data beat offered while FIFO full: not accepted (app_wdf_rdy = 0).

Test Plan:
- Calibration: release reset at cycle 0, CALIB_CYCLES = 64 -> init_calib_complete and app_rdy rise at cycle 64; any app_en before that is not accepted.
- Write then read back: write 0x0123..EF at addr 0x40 (cmd and data in the same cycle), then read 0x40 -> app_rd_data_valid exactly 6 cycles after the read is accepted, data 0x0123..EF, app_rd_data_end = 1; no extra pulses.
- Byte mask: write all-ones, then write zeros with mask 0xFFF0 to the same address, then read -> 0xFF..FF_00000000.
- Command before data: write command at cycle N with wdf_wren = 0 -> app_rdy = 0 from N+1 until data arrives at N+3; a read issued next returns the new data.
- Data before command, then FIFO full:
  - 4 data beats with stall_cmd = 1 -> app_wdf_rdy = 0 after the 4th beat.
  - Release stall_cmd, issue 4 writes to addresses 0, 8, 16, 24 -> readback returns beats in order.
- Reset and errors:
  - Assert reset 2 cycles after a read is accepted -> no app_rd_data_valid; calibration restarts at 0; RAM retains data.
  - app_cmd = 3 -> err_flags = 3'b001.

Source files
------------

// File: rtl/mig_app_responder.sv
// Behavioural stand-in for the MIG 7-series app_* user interface.
// Models calibration delay, write-data FIFO, on-chip RAM and fixed read latency.
module mig_app_responder #(
  parameter int DATA_W       = 128,
  parameter int MEM_AW       = 10,
  parameter int RD_LAT       = 6,
  parameter int CALIB_CYCLES = 64,
  parameter int WDF_DEPTH    = 4
) (
  input  logic                ui_clk,
  input  logic                ui_clk_sync_rst,
  output logic                init_calib_complete,
  input  logic                app_en,
  input  logic [2:0]          app_cmd,
  input  logic [27:0]         app_addr,
  output logic                app_rdy,
  input  logic [DATA_W-1:0]   app_wdf_data,
  input  logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_wren,
  input  logic                app_wdf_end,
  output logic                app_wdf_rdy,
  output logic [DATA_W-1:0]   app_rd_data,
  output logic                app_rd_data_valid,
  output logic                app_rd_data_end,
  input  logic                stall_cmd,
  input  logic                stall_wdf,
  output logic [2:0]          err_flags
);

  localparam int BW = DATA_W / 8;
  localparam int PW = $clog2(WDF_DEPTH);
  localparam int CW = $clog2(CALIB_CYCLES + 1);

  typedef enum logic {CALIB, RUN} state_t;

  state_t            state;
  logic [CW-1:0]     calib_cnt;
  logic [DATA_W-1:0] mem    [2**MEM_AW];
  logic [DATA_W-1:0] fifo_d [WDF_DEPTH];
  logic [BW-1:0]     fifo_m [WDF_DEPTH];
  logic [PW-1:0]     wp, rp;
  logic [PW:0]       cnt;
  logic              wr_pend;
  logic [MEM_AW-1:0] pend_idx;
  logic [RD_LAT-1:0] rd_v;
  logic [DATA_W-1:0] rd_d [RD_LAT];
  logic [2:0]        err;

  logic              run, fifo_empty, fifo_full;
  logic              wdf_acc, cmd_acc, is_wr, is_rd;
  logic              data_avail, wr_now, push, pop;
  logic [MEM_AW-1:0] cmd_idx, wr_idx;
  logic [DATA_W-1:0] src_d;
  logic [BW-1:0]     src_m;
  logic              unused_addr;

  assign unused_addr = ^app_addr[27:MEM_AW+3];

  assign run        = (state == RUN);
  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == (PW+1)'(WDF_DEPTH));

  assign app_wdf_rdy = run && !stall_wdf && !fifo_full;
  assign app_rdy     = run && !stall_cmd && !wr_pend;

  assign wdf_acc = app_wdf_wren && app_wdf_rdy;
  assign cmd_acc = app_en && app_rdy;
  assign cmd_idx = app_addr[MEM_AW+2:3];
  assign is_wr   = cmd_acc && (app_cmd == 3'd0);
  assign is_rd   = cmd_acc && (app_cmd == 3'd1);

  // An empty FIFO lets a same-cycle data beat feed the write directly.
  assign data_avail = !fifo_empty || wdf_acc;
  assign src_d      = fifo_empty ? app_wdf_data : fifo_d[rp];
  assign src_m      = fifo_empty ? app_wdf_mask : fifo_m[rp];
  assign wr_now     = data_avail && (is_wr || wr_pend);
  assign wr_idx     = wr_pend ? pend_idx : cmd_idx;
  assign pop        = wr_now && !fifo_empty;
  assign push       = wdf_acc && !(wr_now && fifo_empty);

  assign app_rd_data       = rd_d[RD_LAT-1];
  assign app_rd_data_valid = rd_v[RD_LAT-1];
  assign app_rd_data_end   = rd_v[RD_LAT-1];
  assign err_flags         = err;

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state               <= CALIB;
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
    end else begin
      unique case (state)
        CALIB: begin
          calib_cnt <= calib_cnt + 1'b1;
          if (calib_cnt == CW'(CALIB_CYCLES - 1)) begin
            state               <= RUN;
            init_calib_complete <= 1'b1;
          end
        end
        RUN: init_calib_complete <= 1'b1;
      endcase
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      wr_pend  <= 1'b0;
      pend_idx <= '0;
    end else begin
      if (push) begin
        fifo_d[wp] <= app_wdf_data;
        fifo_m[wp] <= app_wdf_mask;
        wp         <= wp + 1'b1;
      end
      if (pop)
        rp <= rp + 1'b1;
      if (push && !pop)
        cnt <= cnt + 1'b1;
      else if (pop && !push)
        cnt <= cnt - 1'b1;
      if (wr_pend && data_avail)
        wr_pend <= 1'b0;
      else if (is_wr && !data_avail) begin
        wr_pend  <= 1'b1;
        pend_idx <= cmd_idx;
      end
    end
  end

  // Contents survive reset; only the write strobe is suppressed.
  always_ff @(posedge ui_clk) begin
    if (!ui_clk_sync_rst && wr_now) begin
      for (int b = 0; b < BW; b++)
        if (!src_m[b])
          mem[wr_idx][b*8 +: 8] <= src_d[b*8 +: 8];
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      rd_v <= '0;
      for (int i = 0; i < RD_LAT; i++)
        rd_d[i] <= '0;
    end else begin
      rd_v    <= {rd_v[RD_LAT-2:0], is_rd};
      rd_d[0] <= is_rd ? mem[cmd_idx] : '0;
      for (int i = 1; i < RD_LAT; i++)
        rd_d[i] <= rd_d[i-1];
    end
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst)
      err <= '0;
    else begin
      if (cmd_acc && app_cmd > 3'd1)
        err[0] <= 1'b1;
      if (cmd_acc && app_addr[2:0] != 3'd0)
        err[1] <= 1'b1;
      if (app_wdf_end != app_wdf_wren)
        err[2] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mig_app_responder.sv
// Directed bench for mig_app_responder.
// Read responses are checked by a queue-driven monitor.
module tb_mig_app_responder;

  logic         ui_clk = 1'b0;
  logic         ui_clk_sync_rst = 1'b1;
  logic         init_calib_complete;
  logic         app_en = 1'b0;
  logic [2:0]   app_cmd = 3'd0;
  logic [27:0]  app_addr = '0;
  logic         app_rdy;
  logic [127:0] app_wdf_data = '0;
  logic [15:0]  app_wdf_mask = '0;
  logic         app_wdf_wren = 1'b0;
  logic         app_wdf_end = 1'b0;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         stall_cmd = 1'b0;
  logic         stall_wdf = 1'b0;
  logic [2:0]   err_flags;

  mig_app_responder dut (
    .ui_clk              (ui_clk),
    .ui_clk_sync_rst     (ui_clk_sync_rst),
    .init_calib_complete (init_calib_complete),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_mask        (app_wdf_mask),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid),
    .app_rd_data_end     (app_rd_data_end),
    .stall_cmd           (stall_cmd),
    .stall_wdf           (stall_wdf),
    .err_flags           (err_flags)
  );

  always #5 ui_clk = ~ui_clk;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D2 = 128'hCAFEF00DDEADBEEF1122334455667788;
  localparam logic [127:0] DW = 128'h5A5A5A5AA5A5A5A50F0F0F0FF0F0F0F0;
  localparam logic [127:0] DM = 128'hFFFFFFFFFFFFFFFFFFFFFFFF00000000;

  logic [127:0] beats [4] = '{
    128'h00000000000000000000000000000011,
    128'h22222222222222222222222222222222,
    128'h33333333000000003333333300000000,
    128'h4444444444444444FFFFFFFFFFFFFFFF
  };

  always @(posedge ui_clk)
    cyc <= ui_clk_sync_rst ? 0 : cyc + 1;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge ui_clk) begin
    if (app_rd_data_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rd_unexpected: got valid at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd_data", app_rd_data, e.data);
        check("rd_latency_cycle", 128'(cyc), 128'(e.cyc));
        check("rd_end", 128'(app_rd_data_end), 128'(1));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] c, input logic [27:0] a,
                       input bit wd, input logic [127:0] d,
                       input logic [15:0] m, input logic [127:0] rexp);
    int n = 0;
    app_en       = 1'b1;
    app_cmd      = c;
    app_addr     = a;
    app_wdf_wren = wd;
    app_wdf_end  = wd;
    app_wdf_data = d;
    app_wdf_mask = m;
    @(negedge ui_clk);
    while (!(app_rdy && (!wd || app_wdf_rdy)) && n < 50) begin
      n++;
      @(negedge ui_clk);
    end
    if (n >= 50) begin
      n_cmp++;
      n_err++;
      $display("FAIL cmd_accept_timeout: got app_rdy=%0b expected 1", app_rdy);
    end else if (c == 3'd1) begin
      exp_q.push_back('{rexp, cyc + 6});
    end
    tick();
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
  endtask

  task automatic calib_check(input string tag);
    while (cyc < 63) @(negedge ui_clk);
    check({tag, "_calib_low"}, 128'(init_calib_complete), 128'(0));
    check({tag, "_rdy_low"}, 128'(app_rdy), 128'(0));
    app_en = 1'b0;
    tick();
    @(negedge ui_clk);
    check({tag, "_calib_cycle"}, 128'(cyc), 128'(64));
    check({tag, "_calib_high"}, 128'(init_calib_complete), 128'(1));
    check({tag, "_rdy_high"}, 128'(app_rdy), 128'(1));
    tick();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge ui_clk);
    #1;
    ui_clk_sync_rst = 1'b0;
    @(negedge ui_clk);
    check("rst_calib", 128'(init_calib_complete), 128'(0));
    check("rst_rdy", 128'(app_rdy), 128'(0));
    check("rst_wdf_rdy", 128'(app_wdf_rdy), 128'(0));
    check("rst_rd_valid", 128'(app_rd_data_valid), 128'(0));
    check("rst_rd_end", 128'(app_rd_data_end), 128'(0));
    check("rst_rd_data", app_rd_data, 128'(0));
    check("rst_err", 128'(err_flags), 128'(0));

    // Read request held during calibration must never be taken.
    app_en  = 1'b1;
    app_cmd = 3'd1;
    calib_check("c1");

    issue(3'd0, 28'h40, 1, D1, 16'h0, '0);
    issue(3'd1, 28'h40, 0, '0, 16'h0, D1);
    repeat (8) tick();

    issue(3'd0, 28'h80, 1, '1, 16'h0, '0);
    issue(3'd0, 28'h80, 1, '0, 16'hFFF0, '0);
    issue(3'd1, 28'h80, 0, '0, 16'h0, DM);
    repeat (8) tick();

    // Command ahead of its data.
    issue(3'd0, 28'hC0, 0, '0, 16'h0, '0);
    @(negedge ui_clk);
    check("pend_rdy_n1", 128'(app_rdy), 128'(0));
    tick();
    @(negedge ui_clk);
    check("pend_rdy_n2", 128'(app_rdy), 128'(0));
    tick();
    app_wdf_wren = 1'b1;
    app_wdf_end  = 1'b1;
    app_wdf_data = D2;
    app_wdf_mask = 16'h0;
    @(negedge ui_clk);
    check("pend_rdy_n3", 128'(app_rdy), 128'(0));
    check("pend_wdf_rdy_n3", 128'(app_wdf_rdy), 128'(1));
    tick();
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    @(negedge ui_clk);
    check("pend_rdy_n4", 128'(app_rdy), 128'(1));
    tick();
    issue(3'd1, 28'hC0, 0, '0, 16'h0, D2);
    repeat (8) tick();

    // Data ahead of commands until the FIFO fills.
    stall_cmd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      app_wdf_wren = 1'b1;
      app_wdf_end  = 1'b1;
      app_wdf_data = beats[i];
      app_wdf_mask = 16'h0;
      @(negedge ui_clk);
      check("fifo_wdf_rdy", 128'(app_wdf_rdy), 128'(1));
      tick();
    end
    app_wdf_wren = 1'b0;
    app_wdf_end  = 1'b0;
    @(negedge ui_clk);
    check("fifo_full_wdf_rdy", 128'(app_wdf_rdy), 128'(0));
    tick();
    stall_cmd = 1'b0;
    for (int i = 0; i < 4; i++)
      issue(3'd0, 28'(i * 8), 0, '0, 16'h0, '0);
    @(negedge ui_clk);
    check("fifo_drained_wdf_rdy", 128'(app_wdf_rdy), 128'(1));
    tick();
    for (int i = 0; i < 4; i++)
      issue(3'd1, 28'(i * 8), 0, '0, 16'h0, beats[i]);
    repeat (10) tick();

    // Reset two cycles after a read is accepted.
    issue(3'd1, 28'h40, 0, '0, 16'h0, D1);
    tick();
    ui_clk_sync_rst = 1'b1;
    exp_q.delete();
    repeat (2) tick();
    ui_clk_sync_rst = 1'b0;
    @(negedge ui_clk);
    check("rst2_calib", 128'(init_calib_complete), 128'(0));
    check("rst2_rd_valid", 128'(app_rd_data_valid), 128'(0));
    calib_check("c2");
    issue(3'd1, 28'h40, 0, '0, 16'h0, D1);
    repeat (8) tick();

    // Upper address bits alias onto the same word.
    issue(3'd0, 28'h2040, 1, DW, 16'h0, '0);
    issue(3'd1, 28'h40, 0, '0, 16'h0, DW);
    repeat (8) tick();

    @(negedge ui_clk);
    check("err_clean", 128'(err_flags), 128'(0));
    tick();
    issue(3'd3, 28'h200, 0, '0, 16'h0, '0);
    @(negedge ui_clk);
    check("err_illegal_cmd", 128'(err_flags), 128'(3'b001));
    tick();
    issue(3'd1, 28'h43, 0, '0, 16'h0, DW);
    @(negedge ui_clk);
    check("err_misaligned", 128'(err_flags), 128'(3'b011));
    tick();
    app_wdf_end = 1'b1;
    tick();
    app_wdf_end = 1'b0;
    @(negedge ui_clk);
    check("err_wdf_end", 128'(err_flags), 128'(3'b111));
    tick();

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      tick();
    end
    check("rd_queue_drained", 128'(exp_q.size()), 128'(0));
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
